// File: rtl/regfile_wr_arbiter.sv
// Purpose: shares the register file write port between two writeback requesters through per-requester FIFOs and a round-robin arbiter.
// Latency: a push at edge E into an idle FIFO shows up as wr/reg_id_w/data_in after edge E+1; sustains one write per cycle.
// Backpressure: reqX_ready = !fullX from FIFO occupancy only. Define ZERO_REG_DISCARD_EN to drop writes to register 0.
module regfile_wr_arbiter #(
  parameter int N          = 32,
  parameter int R          = 32,
  parameter int ASIZE      = $clog2(R),
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ASIZE-1:0] req0_id,
  input  logic [N-1:0]     req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ASIZE-1:0] req1_id,
  input  logic [N-1:0]     req1_data,
  output logic             wr,
  output logic [ASIZE-1:0] reg_id_w,
  output logic [N-1:0]     data_in,
  input  logic [ASIZE-1:0] chk_id,
  output logic             chk_pending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic             in_vld    [2];
  logic [ASIZE-1:0] in_id     [2];
  logic [N-1:0]     in_dat    [2];
  logic             fifo_ne   [2];
  logic             fifo_full [2];
  logic             fifo_hit  [2];
  logic             pop       [2];
  logic [ASIZE-1:0] head_id   [2];
  logic [N-1:0]     head_dat  [2];
  logic             last_grant;
  logic             grant_vld;
  logic             grant_idx;

  assign in_vld[0] = req0_valid;
  assign in_vld[1] = req1_valid;
  assign in_id[0]  = req0_id;
  assign in_id[1]  = req1_id;
  assign in_dat[0] = req0_data;
  assign in_dat[1] = req1_data;

  assign req0_ready = !fifo_full[0];
  assign req1_ready = !fifo_full[1];

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [ASIZE-1:0]      id_mem  [FIFO_DEPTH];
    logic [N-1:0]          dat_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_vld;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         cnt;
    logic                  keep;
    logic                  push;
    logic                  hit;

`ifdef ZERO_REG_DISCARD_EN
    // register 0 is hard-wired: the handshake completes but nothing is stored
    assign keep = (in_id[i] != '0);
`else
    assign keep = 1'b1;
`endif

    assign fifo_full[i] = (cnt == CW'(FIFO_DEPTH));
    assign fifo_ne[i]   = (cnt != '0);
    assign push         = in_vld[i] && !fifo_full[i] && keep;
    assign head_id[i]   = id_mem[rd_ptr];
    assign head_dat[i]  = dat_mem[rd_ptr];
    assign fifo_hit[i]  = hit;

    // pointers, occupancy and per-slot valid bits; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        cnt     <= '0;
        ent_vld <= '0;
      end else begin
        if (push) begin
          wr_ptr          <= wr_ptr + 1'b1;
          ent_vld[wr_ptr] <= 1'b1;
        end
        if (pop[i]) begin
          rd_ptr          <= rd_ptr + 1'b1;
          ent_vld[rd_ptr] <= 1'b0;
        end
        if (push && !pop[i]) begin
          cnt <= cnt + 1'b1;
        end else if (!push && pop[i]) begin
          cnt <= cnt - 1'b1;
        end
      end
    end

    // entry payload; unreset because ent_vld/cnt qualify every use
    always_ff @(posedge clk) begin
      if (push) begin
        id_mem[wr_ptr]  <= in_id[i];
        dat_mem[wr_ptr] <= in_dat[i];
      end
    end

    // does any occupied slot target the queried register
    always_comb begin
      hit = 1'b0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (ent_vld[j] && (id_mem[j] == chk_id)) begin
          hit = 1'b1;
        end
      end
    end
  end

  // round-robin pick: on contention take the side not granted last, otherwise whichever has data
  always_comb begin
    grant_vld = fifo_ne[0] || fifo_ne[1];
    grant_idx = 1'b0;
    if (fifo_ne[0] && fifo_ne[1]) begin
      grant_idx = ~last_grant;
    end else if (fifo_ne[1]) begin
      grant_idx = 1'b1;
    end
  end

  assign pop[0] = grant_vld && !grant_idx;
  assign pop[1] = grant_vld && grant_idx;

  // registered write port; address/data hold their last values while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr         <= 1'b0;
      reg_id_w   <= '0;
      data_in    <= '0;
      last_grant <= 1'b1;
    end else begin
      wr <= grant_vld;
      if (grant_vld) begin
        reg_id_w   <= head_id[grant_idx];
        data_in    <= head_dat[grant_idx];
        last_grant <= grant_idx;
      end
    end
  end

  // pending if buffered in either FIFO or currently presented to the register file
  always_comb begin
    chk_pending = fifo_hit[0] || fifo_hit[1] || (wr && (reg_id_w == chk_id));
`ifdef ZERO_REG_DISCARD_EN
    if (chk_id == '0) begin
      chk_pending = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random traffic against a queue-based model.
// Each tick drives inputs after posedge, checks combinational outputs at negedge, registered outputs after posedge.
// Requesters hold valid/id/data while the model says the FIFO is full.
module tb_regfile_wr_arbiter;
  localparam int N     = 32;
  localparam int R     = 32;
  localparam int ASIZE = 5;
  localparam int DEPTH = 2;
`ifdef ZERO_REG_DISCARD_EN
  localparam bit ZERO_DISCARD = 1'b1;
`else
  localparam bit ZERO_DISCARD = 1'b0;
`endif

  typedef struct packed {
    logic [ASIZE-1:0] id;
    logic [N-1:0]     data;
  } txn_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [ASIZE-1:0] req0_id = '0;
  logic [N-1:0]     req0_data = '0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [ASIZE-1:0] req1_id = '0;
  logic [N-1:0]     req1_data = '0;
  logic             wr;
  logic [ASIZE-1:0] reg_id_w;
  logic [N-1:0]     data_in;
  logic [ASIZE-1:0] chk_id = '0;
  logic             chk_pending;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.N(N), .R(R), .ASIZE(ASIZE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_id(req0_id), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_id(req1_id), .req1_data(req1_data),
    .wr(wr), .reg_id_w(reg_id_w), .data_in(data_in),
    .chk_id(chk_id), .chk_pending(chk_pending)
  );

  int checks = 0;
  int errors = 0;

  // model: contents of each FIFO in order, plus the write port and round-robin memory
  txn_t             mq0[$];
  txn_t             mq1[$];
  bit               m_wr   = 1'b0;
  bit               m_last = 1'b1;
  logic [ASIZE-1:0] m_id   = '0;
  logic [N-1:0]     m_data = '0;

  // requester sources
  txn_t s0[$];
  txn_t s1[$];
  bit   hold0 = 1'b0;
  bit   hold1 = 1'b0;
  int   p0 = 100;
  int   p1 = 100;

  int               tick_no = 0;
  logic [ASIZE-1:0] log_id[$];
  int               log_t[$];

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input int id, input logic [N-1:0] data);
    txn_t t;
    t.id   = ASIZE'(id);
    t.data = data;
    return t;
  endfunction

  function automatic bit keep(input logic [ASIZE-1:0] id);
    return !(ZERO_DISCARD && (id == '0));
  endfunction

  function automatic bit m_pending(input logic [ASIZE-1:0] id);
    bit p;
    p = m_wr && (m_id == id);
    foreach (mq0[k]) if (mq0[k].id == id) p = 1'b1;
    foreach (mq1[k]) if (mq1[k].id == id) p = 1'b1;
    if (ZERO_DISCARD && (id == '0)) p = 1'b0;
    return p;
  endfunction

  // one clock cycle; called at posedge+1
  task automatic tick(input bit do_rst, input int chk);
    bit   acc0, acc1, g0, g1;
    txn_t t;
    rst    = do_rst;
    chk_id = (chk < 0) ? ASIZE'($urandom_range(0, 15)) : ASIZE'(chk);
    req0_valid = (s0.size() > 0) && (hold0 || (int'($urandom_range(0, 99)) < p0));
    req1_valid = (s1.size() > 0) && (hold1 || (int'($urandom_range(0, 99)) < p1));
    if (req0_valid) begin req0_id = s0[0].id; req0_data = s0[0].data; end
    if (req1_valid) begin req1_id = s1[0].id; req1_data = s1[0].data; end

    @(negedge clk);
    check("req0_ready", N'(req0_ready), N'(mq0.size() < DEPTH));
    check("req1_ready", N'(req1_ready), N'(mq1.size() < DEPTH));
    check("chk_pending", N'(chk_pending), N'(m_pending(chk_id)));
    acc0 = req0_valid && (mq0.size() < DEPTH);
    acc1 = req1_valid && (mq1.size() < DEPTH);

    @(posedge clk);
    #1;
    if (do_rst) begin
      mq0.delete(); mq1.delete(); s0.delete(); s1.delete();
      hold0 = 1'b0; hold1 = 1'b0;
      m_wr = 1'b0; m_last = 1'b1; m_id = '0; m_data = '0;
    end else begin
      g0 = (mq0.size() > 0) && ((mq1.size() == 0) || m_last);
      g1 = (mq1.size() > 0) && !g0;
      m_wr = g0 || g1;
      if (g0) begin t = mq0.pop_front(); m_id = t.id; m_data = t.data; m_last = 1'b0; end
      if (g1) begin t = mq1.pop_front(); m_id = t.id; m_data = t.data; m_last = 1'b1; end
      if (acc0) begin
        if (keep(s0[0].id)) mq0.push_back(s0[0]);
        void'(s0.pop_front());
      end
      if (acc1) begin
        if (keep(s1[0].id)) mq1.push_back(s1[0]);
        void'(s1.pop_front());
      end
      hold0 = req0_valid && !acc0;
      hold1 = req1_valid && !acc1;
    end
    rst = 1'b0;
    check("wr", N'(wr), N'(m_wr));
    check("reg_id_w", N'(reg_id_w), N'(m_id));
    check("data_in", data_in, m_data);
    if (wr) begin
      log_id.push_back(reg_id_w);
      log_t.push_back(tick_no);
    end
    tick_no++;
  endtask

  initial begin
    logic [ASIZE-1:0] exp_seq[6];
    int               n_exp;
    exp_seq = '{ASIZE'(1), ASIZE'(9), ASIZE'(2), ASIZE'(10), ASIZE'(3), ASIZE'(11)};

    // reset
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_wr", N'(wr), N'(0));
    check("rst_reg_id_w", N'(reg_id_w), N'(0));
    check("rst_data_in", data_in, 32'h0);
    check("rst_ready0", N'(req0_ready), N'(1));
    check("rst_ready1", N'(req1_ready), N'(1));

    // single write, uncontended
    s0.push_back(mk(3, 32'hA5));
    tick(1'b0, 3);
    check("tp1_pend_after_push", N'(chk_pending), N'(1));
    tick(1'b0, 3);
    check("tp1_wr", N'(wr), N'(1));
    check("tp1_id", N'(reg_id_w), N'(3));
    check("tp1_data", data_in, 32'hA5);
    tick(1'b0, 3);
    check("tp1_wr_drop", N'(wr), N'(0));

    // idle hold after a write
    s1.push_back(mk(7, 32'h1234));
    repeat (5) tick(1'b0, -1);
    check("idle_wr", N'(wr), N'(0));
    check("idle_id", N'(reg_id_w), N'(7));
    check("idle_data", data_in, 32'h1234);

    // both requesters loaded: alternate with no gaps, req0 first
    log_id.delete(); log_t.delete();
    for (int k = 1; k <= 3; k++) begin
      s0.push_back(mk(k, 32'h100 + k));
      s1.push_back(mk(k + 8, 32'h900 + k));
    end
    repeat (8) tick(1'b0, -1);
    check("alt_count", N'(log_id.size()), N'(6));
    for (int k = 0; k < 6 && k < log_id.size(); k++) begin
      check($sformatf("alt_seq%0d", k), N'(log_id[k]), N'(exp_seq[k]));
    end
    if (log_t.size() == 6) check("alt_no_gaps", N'(log_t[5] - log_t[0]), N'(5));

    // fill both FIFOs, then reset mid-operation
    for (int k = 0; k < 4; k++) begin
      s0.push_back(mk(12 + k, 32'hDEAD0000 + k));
      s1.push_back(mk(20 + k, 32'hBEEF0000 + k));
    end
    repeat (4) tick(1'b0, -1);
    tick(1'b1, 13);
    check("mrst_wr", N'(wr), N'(0));
    check("mrst_ready0", N'(req0_ready), N'(1));
    check("mrst_ready1", N'(req1_ready), N'(1));
    check("mrst_data", data_in, 32'h0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int id = 0; id < R; id++) begin
      chk_id = ASIZE'(id);
      #1;
      check($sformatf("mrst_pend%0d", id), N'(chk_pending), N'(0));
    end
    @(posedge clk); #1;
    repeat (3) tick(1'b0, -1);

    // register 0 handling
    log_id.delete(); log_t.delete();
    s0.push_back(mk(0, 32'h11));
    s0.push_back(mk(5, 32'h55));
    repeat (5) tick(1'b0, 0);
    n_exp = ZERO_DISCARD ? 1 : 2;
    check("zero_count", N'(log_id.size()), N'(n_exp));
    if (log_id.size() > 0) begin
      check("zero_first", N'(log_id[0]), N'(ZERO_DISCARD ? 5 : 0));
      check("zero_last", N'(log_id[log_id.size() - 1]), N'(5));
    end

    // random traffic with one reset in the middle
    for (int k = 0; k < 400; k++) begin
      if (s0.size() < 4 && $urandom_range(0, 1) == 1)
        s0.push_back(mk(int'($urandom_range(0, 15)), $urandom));
      if (s1.size() < 4 && $urandom_range(0, 1) == 1)
        s1.push_back(mk(int'($urandom_range(0, 15)), $urandom));
      if (k % 50 == 0) begin
        p0 = int'($urandom_range(30, 100));
        p1 = int'($urandom_range(30, 100));
      end
      tick(k == 200, -1);
    end
    p0 = 100; p1 = 100;
    repeat (12) tick(1'b0, -1);
    check("drain_wr", N'(wr), N'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
